// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse key decoder.
// Default timings assume a 50 MHz clock; the SIM_* set keeps simulations short.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS     = 2'd1,
    GAP       = 2'd2,
    WORD_WAIT = 2'd3
  } morse_state_t;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam int DEF_DEBOUNCE_CYCLES   = 500000;
  localparam int DEF_DASH_MIN_CYCLES   = 10000000;
  localparam int DEF_LETTER_GAP_CYCLES = 30000000;
  localparam int DEF_WORD_GAP_CYCLES   = 70000000;
  localparam int DEF_MAX_SYMBOLS       = 6;

  localparam int SIM_DEBOUNCE_CYCLES   = 4;
  localparam int SIM_DASH_MIN_CYCLES   = 20;
  localparam int SIM_LETTER_GAP_CYCLES = 40;
  localparam int SIM_WORD_GAP_CYCLES   = 100;
  localparam int SIM_MAX_SYMBOLS       = 6;

endpackage

// File: rtl/morse_key_decoder_key_debouncer.sv
// Two-flop synchroniser plus debounce counter for the active-low Morse key.
// level is 1 while the key is (debounced) pressed.
module key_debouncer
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk50,
  input  logic rst,
  input  logic key_n,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sample_s;

  assign sample_s = ~sync2_r;

  // Synchroniser flops idle at the released (high) key level.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Level toggles on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      level <= 1'b0;
    end else if (sample_s == level) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_r <= '0;
      level <= ~level;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key decoder: times debounced presses into dots/dashes, collects a letter
// and emits it on a letter gap; a longer silence emits a single word pulse.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int DASH_MIN_CYCLES   = DEF_DASH_MIN_CYCLES,
  parameter int LETTER_GAP_CYCLES = DEF_LETTER_GAP_CYCLES,
  parameter int WORD_GAP_CYCLES   = DEF_WORD_GAP_CYCLES,
  parameter int MAX_SYMBOLS       = DEF_MAX_SYMBOLS
) (
  input  logic                               clk50,
  input  logic                               rst,
  input  logic                               key_n,
  output logic                               key_down,
  output logic                               sym_valid,
  output logic [MAX_SYMBOLS-1:0]             sym_bits,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0]   sym_len,
  output logic                               sym_ovf,
  output logic                               word_valid
);

  localparam int PRESS_W = $clog2(DASH_MIN_CYCLES + 1);
  localparam int GAP_W   = $clog2(WORD_GAP_CYCLES + 1);
  localparam int LEN_W   = $clog2(MAX_SYMBOLS + 1);

  morse_state_t           state_r, state_n;
  logic [PRESS_W-1:0]     press_cnt_r, press_n;
  logic [GAP_W-1:0]       gap_cnt_r, gap_n;
  logic [MAX_SYMBOLS-1:0] buf_bits_r, bits_n;
  logic [LEN_W-1:0]       buf_len_r, len_n;
  logic                   buf_ovf_r, ovf_n;
  logic                   level_s;
  logic                   sym_s;
  logic                   emit_s;
  logic                   word_s;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk50 (clk50),
    .rst   (rst),
    .key_n (key_n),
    .level (level_s)
  );

  // The debouncer output is already a flop, so it drives the LED directly.
  assign key_down = level_s;

  // Next-state, counter and letter-buffer logic.
  always_comb begin
    state_n = state_r;
    press_n = press_cnt_r;
    gap_n   = gap_cnt_r;
    bits_n  = buf_bits_r;
    len_n   = buf_len_r;
    ovf_n   = buf_ovf_r;
    emit_s  = 1'b0;
    word_s  = 1'b0;
    sym_s   = (press_cnt_r >= PRESS_W'(DASH_MIN_CYCLES)) ? SYM_DASH : SYM_DOT;

    case (state_r)
      IDLE: begin
        if (level_s) begin
          state_n = PRESS;
          press_n = PRESS_W'(1);
        end else begin
          state_n = IDLE;
          gap_n   = '0;
        end
      end

      PRESS: begin
        if (level_s) begin
          if (press_cnt_r < PRESS_W'(DASH_MIN_CYCLES)) begin
            press_n = press_cnt_r + 1'b1;
          end else begin
            press_n = press_cnt_r;
          end
        end else begin
          // Symbols beyond capacity are dropped but remembered as overflow.
          if (buf_len_r < LEN_W'(MAX_SYMBOLS)) begin
            bits_n = buf_bits_r | (MAX_SYMBOLS'(sym_s) << buf_len_r);
            len_n  = buf_len_r + 1'b1;
          end else begin
            ovf_n  = 1'b1;
          end
          state_n = GAP;
          gap_n   = GAP_W'(1);
          press_n = '0;
        end
      end

      GAP: begin
        if (level_s) begin
          state_n = PRESS;
          press_n = PRESS_W'(1);
          gap_n   = '0;
        end else if (gap_cnt_r == GAP_W'(LETTER_GAP_CYCLES - 1)) begin
          emit_s  = 1'b1;
          bits_n  = '0;
          len_n   = '0;
          ovf_n   = 1'b0;
          state_n = WORD_WAIT;
          gap_n   = gap_cnt_r + 1'b1;
        end else begin
          gap_n   = gap_cnt_r + 1'b1;
        end
      end

      WORD_WAIT: begin
        if (level_s) begin
          state_n = PRESS;
          press_n = PRESS_W'(1);
          gap_n   = '0;
        end else if (gap_cnt_r == GAP_W'(WORD_GAP_CYCLES - 1)) begin
          word_s  = 1'b1;
          state_n = IDLE;
          gap_n   = '0;
        end else if (gap_cnt_r < GAP_W'(WORD_GAP_CYCLES)) begin
          gap_n   = gap_cnt_r + 1'b1;
        end else begin
          gap_n   = gap_cnt_r;
        end
      end

      default: begin
        state_n = IDLE;
        press_n = '0;
        gap_n   = '0;
        bits_n  = '0;
        len_n   = '0;
        ovf_n   = 1'b0;
      end
    endcase
  end

  // State, counters, buffer and registered outputs.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      press_cnt_r <= '0;
      gap_cnt_r   <= '0;
      buf_bits_r  <= '0;
      buf_len_r   <= '0;
      buf_ovf_r   <= 1'b0;
      sym_valid   <= 1'b0;
      sym_bits    <= '0;
      sym_len     <= '0;
      sym_ovf     <= 1'b0;
      word_valid  <= 1'b0;
    end else begin
      state_r     <= state_n;
      press_cnt_r <= press_n;
      gap_cnt_r   <= gap_n;
      buf_bits_r  <= bits_n;
      buf_len_r   <= len_n;
      buf_ovf_r   <= ovf_n;
      sym_valid   <= emit_s;
      word_valid  <= word_s;
      // Letter outputs hold until the next letter is emitted.
      if (emit_s) begin
        sym_bits <= buf_bits_r;
        sym_len  <= buf_len_r;
        sym_ovf  <= buf_ovf_r;
      end
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Self-checking bench: table-driven letters, directed corner sequences and
// randomized letters checked against an event-level reference model.
module tb_morse_key_decoder;

  localparam int DEB  = 4;
  localparam int DASH = 20;
  localparam int LG   = 40;
  localparam int WG   = 100;
  localparam int MAXS = 6;
  localparam int DLY  = DEB + 2;

  typedef struct {
    bit         is_word;
    int         cyc;
    logic [5:0] bits;
    logic [2:0] len;
    logic       ovf;
  } ev_t;

  typedef struct {
    int         n;
    int         plen [8];
    logic [5:0] bits;
    logic [2:0] len;
    logic       ovf;
  } vec_t;

  logic       clk50 = 1'b0;
  logic       rst   = 1'b1;
  logic       key_n = 1'b1;
  logic       key_down, sym_valid, sym_ovf, word_valid;
  logic [5:0] sym_bits;
  logic [2:0] sym_len;

  int  cyc = 0;
  int  pass_cnt = 0;
  int  chk_cnt = 0;
  ev_t act_q[$];
  ev_t exp_q[$];

  morse_key_decoder #(
    .DEBOUNCE_CYCLES(DEB), .DASH_MIN_CYCLES(DASH), .LETTER_GAP_CYCLES(LG),
    .WORD_GAP_CYCLES(WG), .MAX_SYMBOLS(MAXS)
  ) dut (
    .clk50(clk50), .rst(rst), .key_n(key_n), .key_down(key_down),
    .sym_valid(sym_valid), .sym_bits(sym_bits), .sym_len(sym_len),
    .sym_ovf(sym_ovf), .word_valid(word_valid)
  );

  always #5 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint want);
    chk_cnt++;
    if (act == want) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
  endtask

  // Record every output pulse with the number of the clock edge that produced it.
  always @(negedge clk50) begin
    if (!rst && (sym_valid || word_valid)) begin
      ev_t e;
      check("pulse exclusive", longint'(sym_valid & word_valid), 0);
      e.is_word = word_valid;
      e.cyc     = cyc;
      e.bits    = word_valid ? 6'd0 : sym_bits;
      e.len     = word_valid ? 3'd0 : sym_len;
      e.ovf     = word_valid ? 1'b0 : sym_ovf;
      act_q.push_back(e);
    end
  end

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    key_n = v;
    repeat (n) step();
  endtask

  task automatic expect_sym(input int c, input logic [5:0] b, input logic [2:0] l, input logic o);
    ev_t e;
    e.is_word = 1'b0; e.cyc = c; e.bits = b; e.len = l; e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic expect_word(input int c);
    ev_t e;
    e.is_word = 1'b1; e.cyc = c; e.bits = 6'd0; e.len = 3'd0; e.ovf = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, " event count"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " kind"}, act_q[i].is_word, exp_q[i].is_word);
      check({tag, " cycle"}, act_q[i].cyc, exp_q[i].cyc);
      if (!exp_q[i].is_word) begin
        check({tag, " sym_bits"}, act_q[i].bits, exp_q[i].bits);
        check({tag, " sym_len"}, act_q[i].len, exp_q[i].len);
        check({tag, " sym_ovf"}, act_q[i].ovf, exp_q[i].ovf);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  // Sends one letter; krel is the cycle at which the last raw release was driven.
  task automatic send_letter(input int n, input int plen [8], input int gaps [8],
                             input int tail, output int krel);
    krel = cyc;
    for (int i = 0; i < n; i++) begin
      hold(1'b0, plen[i]);
      krel = cyc;
      hold(1'b1, (i == n - 1) ? tail : gaps[i]);
    end
  endtask

  // Reference letter code straight from the symbol rules.
  function automatic void model_letter(input int n, input int plen [8], output logic [5:0] bits,
                                       output logic [2:0] len, output logic ovf);
    bits = 6'd0;
    for (int i = 0; i < n && i < MAXS; i++) bits[i] = (plen[i] >= DASH);
    len = 3'((n > MAXS) ? MAXS : n);
    ovf = (n > MAXS);
  endfunction

  initial begin
    vec_t       tbl [7];
    int         gaps10 [8];
    int         plen [8];
    int         gaps [8];
    int         krel, k0, tail, n, r;
    logic       kd_any;
    logic [5:0] mb;
    logic [2:0] ml;
    logic       mo;

    tbl[0] = '{1, '{10, 0, 0, 0, 0, 0, 0, 0}, 6'b000000, 3'd1, 1'b0};
    tbl[1] = '{4, '{30, 10, 30, 10, 0, 0, 0, 0}, 6'b000101, 3'd4, 1'b0};
    tbl[2] = '{7, '{10, 10, 10, 10, 10, 10, 10, 0}, 6'b000000, 3'd6, 1'b1};
    tbl[3] = '{1, '{30, 0, 0, 0, 0, 0, 0, 0}, 6'b000001, 3'd1, 1'b0};
    tbl[4] = '{2, '{19, 20, 0, 0, 0, 0, 0, 0}, 6'b000010, 3'd2, 1'b0};
    tbl[5] = '{6, '{25, 25, 25, 25, 25, 25, 0, 0}, 6'b111111, 3'd6, 1'b0};
    tbl[6] = '{8, '{30, 10, 30, 10, 30, 10, 30, 30}, 6'b010101, 3'd6, 1'b1};
    for (int i = 0; i < 8; i++) gaps10[i] = 10;

    // Reset values
    repeat (3) step();
    check("reset key_down", key_down, 0);
    check("reset sym_valid", sym_valid, 0);
    check("reset sym_bits", sym_bits, 0);
    check("reset sym_len", sym_len, 0);
    check("reset sym_ovf", sym_ovf, 0);
    check("reset word_valid", word_valid, 0);
    rst = 1'b0;
    repeat (5) step();

    // Table-driven letters, each followed by a letter-but-not-word gap
    for (int t = 0; t < 7; t++) begin
      send_letter(tbl[t].n, tbl[t].plen, gaps10, 50, krel);
      expect_sym(krel + DLY + LG, tbl[t].bits, tbl[t].len, tbl[t].ovf);
      compare_events($sformatf("table%0d", t));
    end
    hold(1'b1, 200);
    expect_word(krel + DLY + WG);
    compare_events("word gap");

    // Short glitches never move the debounced level
    kd_any = 1'b0;
    key_n = 1'b0; repeat (2) begin step(); kd_any |= key_down; end
    key_n = 1'b1; repeat (100) begin step(); kd_any |= key_down; end
    key_n = 1'b0; repeat (DEB - 1) begin step(); kd_any |= key_down; end
    key_n = 1'b1; repeat (200) begin step(); kd_any |= key_down; end
    check("glitch key_down", kd_any, 0);
    compare_events("glitch");

    // Dot, 60-cycle gap, dash: two letters, outputs held in between
    hold(1'b0, 10);
    krel = cyc;
    hold(1'b1, 60);
    expect_sym(krel + DLY + LG, 6'b000000, 3'd1, 1'b0);
    hold(1'b0, 30);
    check("hold sym_len", sym_len, 1);
    check("hold sym_bits", sym_bits, 0);
    check("hold sym_valid", sym_valid, 0);
    krel = cyc;
    hold(1'b1, WG + DLY + 4);
    expect_sym(krel + DLY + LG, 6'b000001, 3'd1, 1'b0);
    expect_word(krel + DLY + WG);
    compare_events("two letters");

    // Reset mid-letter with the key still held
    hold(1'b0, 10);
    hold(1'b1, 10);
    hold(1'b0, 15);
    rst = 1'b1;
    repeat (3) step();
    check("rst key_down", key_down, 0);
    check("rst sym_valid", sym_valid, 0);
    check("rst sym_len", sym_len, 0);
    check("rst sym_bits", sym_bits, 0);
    check("rst word_valid", word_valid, 0);
    rst = 1'b0;
    k0 = cyc;
    repeat (DEB + 1) step();
    check("post-rst key_down early", key_down, 0);
    step();
    check("post-rst key_down at 6", key_down, 1);
    check("post-rst delay", cyc - k0, DEB + 2);
    hold(1'b0, 4);
    krel = cyc;
    hold(1'b1, WG + DLY + 4);
    expect_sym(krel + DLY + LG, 6'b000000, 3'd1, 1'b0);
    expect_word(krel + DLY + WG);
    compare_events("after reset");

    // Randomized letters against the reference model
    for (int l = 0; l < 30; l++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 9);
        plen[i] = (r == 0) ? DASH - 1 : (r == 1) ? DASH : int'($urandom_range(6, 35));
        r = $urandom_range(0, 9);
        gaps[i] = (r == 0) ? LG - 1 : int'($urandom_range(6, 38));
      end
      r = $urandom_range(0, 4);
      tail = (r == 0) ? LG : (r == 1) ? WG - 1 : (r == 2) ? WG : int'($urandom_range(LG, WG + 30));
      if (l == 29) tail = WG + DLY + 4;
      send_letter(n, plen, gaps, tail, krel);
      model_letter(n, plen, mb, ml, mo);
      expect_sym(krel + DLY + LG, mb, ml, mo);
      if (tail >= WG) expect_word(krel + DLY + WG);
    end
    compare_events("random");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
